// File: rtl/mlp_pkg.sv
// Shared MLP datapath types and constants: FSM state encoding, data width,
// ReLU ceiling and default fixed-point fraction.
package mlp_pkg;
    localparam int DATA_W   = 8;
    localparam int RELU_MAX = 127;
    localparam int FRAC_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        ACT
    } state_t;
endpackage

// File: rtl/neuron_mac_if.sv
// Operand/result bundle between a neuron_mac and its operand memories and
// downstream result register; master is the neuron's environment.
interface neuron_mac_if #(
    parameter int IDX_W = 5
);
    import mlp_pkg::*;

    logic                     start;
    logic signed [DATA_W-1:0] bias;
    logic signed [DATA_W-1:0] x_in;
    logic signed [DATA_W-1:0] w_in;
    logic [IDX_W-1:0]         idx;
    logic                     busy;
    logic [DATA_W-1:0]        y;
    logic                     y_valid;

    modport master (
        output start, bias, x_in, w_in,
        input  idx, busy, y, y_valid
    );

    modport slave (
        input  start, bias, x_in, w_in,
        output idx, busy, y, y_valid
    );
endinterface

// File: rtl/relu_sat8.sv
// Rescale a signed accumulator by FRAC and clamp it to the 8-bit ReLU range
// 0..RELU_MAX; purely combinational.
module relu_sat8
    import mlp_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int FRAC  = FRAC_DEF
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic [DATA_W-1:0]       y
);
    localparam logic signed [ACC_W-1:0] CEIL = ACC_W'(RELU_MAX);

    logic signed [ACC_W-1:0] s;

    assign s = acc >>> FRAC;

    always_comb begin
        y = '0;
        if (s[ACC_W-1]) begin
            y = '0;
        end else if (s > CEIL) begin
            y = DATA_W'(RELU_MAX);
        end else begin
            y = s[DATA_W-1:0];
        end
    end
endmodule

// File: rtl/neuron_mac.sv
// Single-neuron MAC: bias + sum(x*w) over N_INPUTS, rescaled, ReLU-saturated.
// Result N_INPUTS+2 edges after start; start is ignored while busy (no backpressure on y).
module neuron_mac
    import mlp_pkg::*;
#(
    parameter int N_INPUTS = 8,
    parameter int IDX_W    = 5,
    parameter int ACC_W    = 24,
    parameter int FRAC     = FRAC_DEF
) (
    input  logic         clk,
    input  logic         rst,
    neuron_mac_if.slave  bus
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     busy_q, busy_d;
    logic [DATA_W-1:0]        y_q, y_d;
    logic                     y_valid_q, y_valid_d;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    bias_ext;
    logic [DATA_W-1:0]          relu_y;

    assign prod     = bus.x_in * bus.w_in;
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    assign bias_ext = {{(ACC_W-DATA_W){bus.bias[DATA_W-1]}}, bus.bias};

    relu_sat8 #(
        .ACC_W (ACC_W),
        .FRAC  (FRAC)
    ) u_relu (
        .acc (acc_q),
        .y   (relu_y)
    );

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        busy_d    = busy_q;
        y_d       = y_q;
        y_valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ACC;
                    // Bias is pre-scaled so it lines up with the product's fraction bits.
                    acc_d   = bias_ext <<< FRAC;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ACC: begin
                acc_d = acc_q + prod_ext;
                if (idx_q == LAST_IDX) begin
                    state_d = ACT;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ACT: begin
                y_d       = relu_y;
                y_valid_d = 1'b1;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            busy_q    <= busy_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign bus.idx     = idx_q;
    assign bus.busy    = busy_q;
    assign bus.y       = y_q;
    assign bus.y_valid = y_valid_q;
endmodule

// File: tb/tb_neuron_mac.sv
// Scoreboard bench for neuron_mac with N_INPUTS=4: stimulus queues expected
// results and their arrival cycle, a negedge monitor pops on every y_valid.
module tb_neuron_mac;
    localparam int N = 4;

    typedef struct {
        logic [7:0] y;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    logic signed [7:0] xmem [N];
    logic signed [7:0] wmem [N];

    neuron_mac_if #(.IDX_W(5)) bus ();

    neuron_mac #(
        .N_INPUTS (N),
        .IDX_W    (5),
        .ACC_W    (24),
        .FRAC     (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Operand memories read combinationally from idx
    assign bus.x_in = xmem[bus.idx[1:0]];
    assign bus.w_in = wmem[bus.idx[1:0]];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fill(input logic signed [7:0] x, input logic signed [7:0] w);
        for (int i = 0; i < N; i++) begin
            xmem[i] = x;
            wmem[i] = w;
        end
    endtask

    // Called at a negedge; returns at a negedge with the FSM idle again.
    task automatic eval(input logic signed [7:0] b, input logic [7:0] ey, output int bcnt);
        bcnt      = 0;
        bus.start = 1'b1;
        bus.bias  = b;
        sb.push_back('{y: ey, cyc: cyc + N + 2});
        for (int i = 0; i < N + 4; i++) begin
            @(negedge clk);
            if (i == 0) bus.start = 1'b0;
            bcnt += int'(bus.busy);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (bus.y_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_y_valid: got y=%0d with no pending result (cycle %0d)", bus.y, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("y_value", int'(bus.y), int'(e.y));
                chk("y_latency", cyc, e.cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bcnt;
        bit found;
        bus.start = 1'b0;
        bus.bias  = '0;
        fill(8'sd16, 8'sd16);
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_idx", int'(bus.idx), 0);
        chk("reset_y", int'(bus.y), 0);
        chk("reset_y_valid", int'(bus.y_valid), 0);
        rst = 1'b0;
        @(negedge clk);

        // 4 * 256 = 1024 -> 64
        eval(8'sd0, 8'd64, bcnt);
        chk("basic_busy_cycles", bcnt, N + 1);
        chk("idle_idx", int'(bus.idx), 0);
        // (48 + 1024) >>> 4 = 67
        eval(8'sd3, 8'd67, bcnt);
        // -1024 -> -64 -> clipped
        fill(8'sd16, -8'sd16);
        eval(8'sd0, 8'd0, bcnt);
        // 4 * 16129 >>> 4 = 4032 -> saturated
        fill(8'sd127, 8'sd127);
        eval(8'sd0, 8'd127, bcnt);
        // 256 + 512 - 512 - 384 + 160 = 32 -> 2
        xmem[0] = 8'sd16;  wmem[0] = 8'sd16;
        xmem[1] = 8'sd32;  wmem[1] = 8'sd16;
        xmem[2] = -8'sd16; wmem[2] = 8'sd32;
        xmem[3] = 8'sd48;  wmem[3] = -8'sd8;
        eval(8'sd10, 8'd2, bcnt);

        // Reset in the middle of an evaluation
        fill(8'sd16, 8'sd16);
        bus.start = 1'b1;
        bus.bias  = 8'sd0;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 10 && bus.idx != 5'd2; i++) @(negedge clk);
        chk("midop_reached_idx2", int'(bus.idx), 2);
        rst = 1'b1;
        @(negedge clk);
        chk("midop_rst_busy", int'(bus.busy), 0);
        chk("midop_rst_idx", int'(bus.idx), 0);
        chk("midop_rst_y", int'(bus.y), 0);
        chk("midop_rst_y_valid", int'(bus.y_valid), 0);
        rst = 1'b0;
        @(negedge clk);
        eval(8'sd0, 8'd64, bcnt);

        // Starts while busy must not re-sample bias or restart
        bus.start = 1'b1;
        bus.bias  = 8'sd3;
        sb.push_back('{y: 8'd67, cyc: cyc + N + 2});
        @(negedge clk);
        bus.start = 1'b0;
        bus.bias  = 8'sd100;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);

        // Back-to-back: new start in the y_valid cycle
        bus.start = 1'b1;
        bus.bias  = 8'sd0;
        sb.push_back('{y: 8'd64, cyc: cyc + N + 2});
        @(negedge clk);
        bus.start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            if (bus.y_valid) found = 1'b1;
        end
        chk("b2b_first_y_valid_seen", int'(found), 1);
        eval(8'sd3, 8'd67, bcnt);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
